// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: FSM states, request kinds and access size codes.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } kind_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Encoding 11 behaves as a full word everywhere.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane logic: byteenable, store data shift, load extract/extend, misalignment flag.
// Purely combinational.
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [31:0] store_data,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  sz;
  logic [31:0] shifted;

  always_comb begin
    sz         = norm_size(size);
    shifted    = readdata >> {offset, 3'b000};
    writedata  = store_data << {offset, 3'b000};
    byteenable = 4'b1111;
    misaligned = 1'b0;
    load_data  = readdata;
    case (sz)
      SZ_BYTE: begin
        byteenable = 4'b0001 << offset;
        load_data  = {{24{load_signed & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        byteenable = offset[1] ? 4'b1100 : 4'b0011;
        misaligned = offset[0];
        load_data  = {{16{load_signed & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        byteenable = 4'b1111;
        misaligned = |offset;
        load_data  = readdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Avalon-MM master sequencing CPU fetches, loads and stores (IDLE -> ACCESS -> RESP).
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_fetch,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [31:0] pc,
  input  logic [31:0] data_addr,
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [31:0] store_data,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] instr_data,
  output logic        instr_valid,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        store_done,
  output logic        busy,
  output logic        align_err,
  output logic        timeout_err
);

  state_t      state, state_next;
  kind_t       kind_q, sel_kind;
  logic [1:0]  off_q, size_q;
  logic        signed_q;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic        any_req;
  logic        accept, reject, complete, abort, tmo_hit;

  logic [1:0]  lane_off, lane_size;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;
  logic        lane_misaligned;

  // Fetch wins over load, load over store.
  always_comb begin
    any_req  = req_fetch | req_load | req_store;
    sel_kind = FETCH;
    sel_addr = pc;
    sel_size = SZ_WORD;
    if (!req_fetch) begin
      sel_addr = data_addr;
      sel_size = size;
      sel_kind = req_load ? LOAD : STORE;
    end
  end

  // The lane unit sees the incoming request while idle and the latched one afterwards.
  assign lane_off  = (state == IDLE) ? sel_addr[1:0] : off_q;
  assign lane_size = (state == IDLE) ? sel_size : size_q;

  byte_lane_unit u_lanes (
    .offset      (lane_off),
    .size        (lane_size),
    .load_signed (signed_q),
    .store_data  (store_data),
    .readdata    (avm_readdata),
    .byteenable  (lane_be),
    .writedata   (lane_wdata),
    .load_data   (lane_load),
    .misaligned  (lane_misaligned)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != ACCESS || !avm_waitrequest) wait_cnt <= '0;
    else                                              wait_cnt <= wait_cnt + TW'(1);
  end

  assign tmo_hit = avm_waitrequest && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) timeout_err <= 1'b0;
    else       timeout_err <= abort;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (lane_misaligned) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!avm_waitrequest) begin
          complete   = 1'b1;
          state_next = RESP;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q         <= FETCH;
      off_q          <= 2'b00;
      size_q         <= SZ_BYTE;
      signed_q       <= 1'b0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'b0000;
      avm_writedata  <= '0;
      instr_data     <= '0;
      instr_valid    <= 1'b0;
      load_data      <= '0;
      load_valid     <= 1'b0;
      store_done     <= 1'b0;
      align_err      <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      load_valid  <= 1'b0;
      store_done  <= 1'b0;
      align_err   <= reject;
      if (accept) begin
        kind_q         <= sel_kind;
        off_q          <= sel_addr[1:0];
        size_q         <= sel_size;
        signed_q       <= load_signed;
        avm_address    <= {sel_addr[31:2], 2'b00};
        avm_read       <= (sel_kind != STORE);
        avm_write      <= (sel_kind == STORE);
        avm_byteenable <= lane_be;
        if (sel_kind == STORE) avm_writedata <= lane_wdata;
      end
      if (complete || abort) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
      end
      if (complete) begin
        case (kind_q)
          FETCH: begin
            instr_data  <= avm_readdata;
            instr_valid <= 1'b1;
          end
          LOAD: begin
            load_data  <= lane_load;
            load_valid <= 1'b1;
          end
          default: store_done <= 1'b1;
        endcase
      end
    end
  end

endmodule
